// File: rtl/n_bitmultiplier_pkg.sv
// rtl/n_bitmultiplier_pkg.sv - shared constants and Baugh-Wooley helper for n_bitmultiplier
// Latency depends on N_BITMULTIPLIER_PIPE_EN.
package n_bitmultiplier_pkg;

  localparam int DEFAULT_NUM_BITS = 8;
  localparam int MAX_PRODUCT_W    = 128;

`ifdef N_BITMULTIPLIER_PIPE_EN
  localparam int MULT_LATENCY = 2;
`else
  localparam int MULT_LATENCY = 1;
`endif

  // Modified Baugh-Wooley sign correction: +2^N and +2^(2N-1), taken modulo 2^(2N).
  function automatic logic [MAX_PRODUCT_W-1:0] bw_correction(input int n);
    return (MAX_PRODUCT_W'(1) << n) | (MAX_PRODUCT_W'(1) << (2 * n - 1));
  endfunction

endpackage

// File: rtl/csa_row.sv
// rtl/csa_row.sv - one row of full adders reducing sum, carry and partial-product vectors
module csa_row #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] sum_in,
  input  logic [WIDTH-1:0] carry_in,
  input  logic [WIDTH-1:0] pp,
  output logic [WIDTH-1:0] sum_out,
  output logic [WIDTH-1:0] carry_out
);

  logic [WIDTH-2:0] maj;

  // The carry out of the top column falls off the 2N-bit result and is dropped.
  assign sum_out   = sum_in ^ carry_in ^ pp;
  assign maj       = (sum_in[WIDTH-2:0] & carry_in[WIDTH-2:0]) |
                     (sum_in[WIDTH-2:0] & pp[WIDTH-2:0]) |
                     (carry_in[WIDTH-2:0] & pp[WIDTH-2:0]);
  assign carry_out = {maj, 1'b0};

endmodule

// File: rtl/n_bitmultiplier.sv
// rtl/n_bitmultiplier.sv - signed Baugh-Wooley carry-save multiplier with registered 2N-bit product
// Optional N_BITMULTIPLIER_PIPE_EN adds a register between the reduction and the final adder.
module n_bitmultiplier
  import n_bitmultiplier_pkg::*;
#(
  parameter int NUM_BITS = DEFAULT_NUM_BITS
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic [NUM_BITS-1:0]     a,
  input  logic [NUM_BITS-1:0]     b,
  input  logic                    in_valid,
  output logic [2*NUM_BITS-1:0]   product,
  output logic                    out_valid
);

  localparam int W = 2 * NUM_BITS;
  localparam logic [MAX_PRODUCT_W-1:0] CORR_FULL = bw_correction(NUM_BITS);
  localparam logic [W-1:0] CORR = CORR_FULL[W-1:0];

  logic [W-1:0] rows      [NUM_BITS];
  logic [W-1:0] sum_chain [NUM_BITS-1];
  logic [W-1:0] carry_chain [NUM_BITS-1];

  // Terms pairing exactly one sign bit are inverted (NAND); the rest are plain ANDs.
  for (genvar gi = 0; gi < NUM_BITS; gi++) begin : g_row
    logic [NUM_BITS-1:0] bits;
    for (genvar gj = 0; gj < NUM_BITS; gj++) begin : g_bit
      if ((gi == NUM_BITS - 1) != (gj == NUM_BITS - 1)) begin : g_nand
        assign bits[gj] = ~(a[gj] & b[gi]);
      end else begin : g_and
        assign bits[gj] = a[gj] & b[gi];
      end
    end
    assign rows[gi] = {{NUM_BITS{1'b0}}, bits} << gi;
  end

  // Row 0 never occupies bits N and above, so the correction constant merges into it for free.
  assign sum_chain[0]   = rows[0] | CORR;
  assign carry_chain[0] = rows[1];

  for (genvar gk = 0; gk < NUM_BITS - 2; gk++) begin : g_csa
    csa_row #(.WIDTH(W)) u_csa_row (
      .sum_in    (sum_chain[gk]),
      .carry_in  (carry_chain[gk]),
      .pp        (rows[gk+2]),
      .sum_out   (sum_chain[gk+1]),
      .carry_out (carry_chain[gk+1])
    );
  end

  logic [W-1:0] fin_sum;
  logic [W-1:0] fin_carry;
  logic         fin_valid;

`ifdef N_BITMULTIPLIER_PIPE_EN
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      fin_sum   <= '0;
      fin_carry <= '0;
      fin_valid <= 1'b0;
    end else begin
      fin_sum   <= sum_chain[NUM_BITS-2];
      fin_carry <= carry_chain[NUM_BITS-2];
      fin_valid <= in_valid;
    end
  end
`else
  assign fin_sum   = sum_chain[NUM_BITS-2];
  assign fin_carry = carry_chain[NUM_BITS-2];
  assign fin_valid = in_valid;
`endif

  logic [W-1:0] cpa_sum;
  logic [W-1:0] cpa_cy;

  assign cpa_cy[0] = 1'b0;
  for (genvar gb = 0; gb < W; gb++) begin : g_cpa
    assign cpa_sum[gb] = fin_sum[gb] ^ fin_carry[gb] ^ cpa_cy[gb];
    if (gb < W - 1) begin : g_cy
      assign cpa_cy[gb+1] = (fin_sum[gb] & fin_carry[gb]) |
                            (fin_sum[gb] & cpa_cy[gb]) |
                            (fin_carry[gb] & cpa_cy[gb]);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      product   <= '0;
      out_valid <= 1'b0;
    end else begin
      product   <= cpa_sum;
      out_valid <= fin_valid;
    end
  end

endmodule

// File: tb/tb_n_bitmultiplier.sv
// tb/tb_n_bitmultiplier.sv - directed and exhaustive self-checking bench for n_bitmultiplier
module tb_n_bitmultiplier;
  import n_bitmultiplier_pkg::*;

  localparam int N = 8;
  localparam int L = MULT_LATENCY;

  logic           clk;
  logic           n_rst;
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic           in_valid;
  logic [2*N-1:0] product;
  logic           out_valid;

  int vec_count;
  int err_count;

  logic [2*N-1:0] q_prod [$];
  logic           q_val  [$];

  n_bitmultiplier #(.NUM_BITS(N)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .a         (a),
    .b         (b),
    .in_valid  (in_valid),
    .product   (product),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_count++;
    if (got !== exp) begin
      err_count++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [2*N-1:0] ref_mul(input logic [N-1:0] x, input logic [N-1:0] y);
    logic [2*N-1:0] xe;
    logic [2*N-1:0] ye;
    xe = {{N{x[N-1]}}, x};
    ye = {{N{y[N-1]}}, y};
    return xe * ye;
  endfunction

  // Hold one operand pair for the full latency, then check it (called at a negedge).
  task automatic directed(input string tag, input logic [N-1:0] av, input logic [N-1:0] bv,
                          input logic [2*N-1:0] exp);
    a = av;
    b = bv;
    in_valid = 1'b1;
    repeat (L) @(negedge clk);
    check({tag, ".product"}, 32'(product), 32'(exp));
    check({tag, ".valid"}, 32'(out_valid), 32'd1);
  endtask

  // Streaming: one pair per cycle, expectations retired after the latency.
  task automatic stream(input logic [N-1:0] av, input logic [N-1:0] bv, input logic v);
    logic [2*N-1:0] ep;
    logic           ev;
    a = av;
    b = bv;
    in_valid = v;
    q_prod.push_back(ref_mul(av, bv));
    q_val.push_back(v);
    @(negedge clk);
    if (q_prod.size() >= L) begin
      ep = q_prod.pop_front();
      ev = q_val.pop_front();
      check("sweep.product", 32'(product), 32'(ep));
      check("sweep.valid", 32'(out_valid), 32'(ev));
    end
  endtask

  initial begin
    vec_count = 0;
    err_count = 0;
    n_rst = 1'b0;
    a = '0;
    b = '0;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("reset.product", 32'(product), 32'h0);
    check("reset.valid", 32'(out_valid), 32'h0);
    n_rst = 1'b1;

    directed("d_3x5",     8'h03, 8'h05, 16'h000F);
    directed("d_m1x1",    8'hFF, 8'h01, 16'hFFFF);
    directed("d_m1xm1",   8'hFF, 8'hFF, 16'h0001);
    directed("d_minxmin", 8'h80, 8'h80, 16'h4000);
    directed("d_maxxmin", 8'h7F, 8'h80, 16'hC080);
    directed("d_maxxmax", 8'h7F, 8'h7F, 16'h3F01);
    directed("d_0xA5",    8'h00, 8'hA5, 16'h0000);
    directed("d_5Ax0",    8'h5A, 8'h00, 16'h0000);
    directed("d_minxm1",  8'h80, 8'hFF, 16'h0080);
    directed("d_2xm2",    8'h02, 8'hFE, 16'hFFFC);

    for (int i = 0; i < 65536; i++) begin
      logic [15:0] pair;
      pair = 16'(i);
      stream(pair[15:8], pair[7:0], 1'b1);
    end
    while (q_prod.size() > 0) stream(8'h00, 8'h00, 1'b0);
    q_prod.delete();
    q_val.delete();

    // Mid-cycle asynchronous reset after a valid result is visible.
    directed("pre_rst", 8'h7F, 8'h7F, 16'h3F01);
    #2 n_rst = 1'b0;
    #1;
    check("async_rst.product", 32'(product), 32'h0);
    check("async_rst.valid", 32'(out_valid), 32'h0);
    @(posedge clk);
    #1;
    check("held_rst.product", 32'(product), 32'h0);
    check("held_rst.valid", 32'(out_valid), 32'h0);
    @(negedge clk);
    a = 8'h03;
    b = 8'h05;
    in_valid = 1'b1;
    n_rst = 1'b1;
    @(negedge clk);
    a = 8'h12;
    b = 8'h34;
    in_valid = 1'b0;
    repeat (L - 1) @(negedge clk);
    check("post_rst.product", 32'(product), 32'h000F);
    check("post_rst.valid", 32'(out_valid), 32'h1);
    @(negedge clk);
    check("invalid.product", 32'(product), 32'h03A8);
    check("invalid.valid", 32'(out_valid), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule
